// File: rtl/exception_vector_unit.sv
// Exception sequencer: captures EPC, fetches the handler byte from the vector table, then redirects the PC.
// Optional build macro EXC_CAUSE_REG_EN makes exc_cause a registered cause code (tied to 0 otherwise).
module exception_vector_unit #(
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] VEC_BASE    = 32'd253,
  parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        invalid_opcode,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] exc_addr,
  output logic        mem_read,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] handler_pc,
  output logic        ex_control,
  output logic        pc_write,
  output logic        exc_busy,
  output logic [1:0]  exc_cause
);

  typedef enum logic [1:0] {IDLE, WAIT, REDIRECT} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [1:0] vec_idx;
  logic [1:0] cause_sel;
  logic       any_flag;
  logic       unused_mem_hi;

  // Only the low byte of the vector entry is a handler address.
  assign unused_mem_hi = ^mem_data_in[31:8];

  always_comb begin
    cause_sel = 2'd0;
    if (invalid_opcode)   cause_sel = 2'd1;
    else if (overflow)    cause_sel = 2'd2;
    else if (div_zero)    cause_sel = 2'd3;
  end

  assign any_flag = invalid_opcode | overflow | div_zero;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (any_flag) state_next = WAIT;
      WAIT:     if (wait_cnt == 4'd0) state_next = REDIRECT;
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      vec_idx    <= 2'd0;
      epc_out    <= 32'd0;
      epc_write  <= 1'b0;
      handler_pc <= 32'd0;
    end else begin
      state     <= state_next;
      epc_write <= 1'b0;
      case (state)
        IDLE: begin
          if (any_flag) begin
            vec_idx   <= cause_sel;
            epc_out   <= pc_in - EPC_OFFSET;
            epc_write <= 1'b1;
            wait_cnt  <= 4'(MEM_LATENCY - 1);
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) handler_pc <= {24'b0, mem_data_in[7:0]};
          else                  wait_cnt   <= wait_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_read   = (state == WAIT);
  assign exc_addr   = (state == WAIT) ? (VEC_BASE + 32'(vec_idx) - 32'd1) : 32'd0;
  assign ex_control = (state == REDIRECT);
  assign pc_write   = (state == REDIRECT);
  assign exc_busy   = (state != IDLE);

`ifdef EXC_CAUSE_REG_EN
  always_ff @(posedge clk) begin
    if (reset)                       exc_cause <= 2'd0;
    else if (state == IDLE && any_flag) exc_cause <= cause_sel;
  end
`else
  assign exc_cause = 2'b00;
`endif

endmodule

// File: tb/tb_exception_vector_unit.sv
// Testbench for exception_vector_unit: directed vector table, idle hold, and randomized run against a cycle model.
module tb_exception_vector_unit;

  localparam int ML = 2;
`ifdef EXC_CAUSE_REG_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        invalid_opcode = 1'b0;
  logic        overflow = 1'b0;
  logic        div_zero = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] mem_data_in = 32'd0;
  logic [31:0] exc_addr;
  logic        mem_read;
  logic [31:0] epc_out;
  logic        epc_write;
  logic [31:0] handler_pc;
  logic        ex_control;
  logic        pc_write;
  logic        exc_busy;
  logic [1:0]  exc_cause;

  int checks = 0;
  int failures = 0;

  exception_vector_unit #(
    .MEM_LATENCY(ML),
    .VEC_BASE(32'd253),
    .EPC_OFFSET(32'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .invalid_opcode(invalid_opcode),
    .overflow(overflow),
    .div_zero(div_zero),
    .pc_in(pc_in),
    .mem_data_in(mem_data_in),
    .exc_addr(exc_addr),
    .mem_read(mem_read),
    .epc_out(epc_out),
    .epc_write(epc_write),
    .handler_pc(handler_pc),
    .ex_control(ex_control),
    .pc_write(pc_write),
    .exc_busy(exc_busy),
    .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        mem_read;
    logic [31:0] exc_addr;
    logic        epc_write;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
    logic        redirect;
    logic [1:0]  cause;
  } out_t;

  typedef struct {
    logic        rst;
    logic [2:0]  flags;
    logic [31:0] pc;
    logic [31:0] mem;
    out_t        exp;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [2:0] f, logic [31:0] pc, logic [31:0] mem,
                              logic busy, logic mr, logic [31:0] addr, logic ew,
                              logic [31:0] epc, logic [31:0] hp, logic redir, logic [1:0] cause);
    vec_t r;
    r.rst = rst; r.flags = f; r.pc = pc; r.mem = mem;
    r.exp.busy = busy; r.exp.mem_read = mr; r.exp.exc_addr = addr; r.exp.epc_write = ew;
    r.exp.epc_out = epc; r.exp.handler_pc = hp; r.exp.redirect = redir;
    r.exp.cause = CAUSE_EN ? cause : 2'd0;
    return r;
  endfunction

  task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s actual=%h required=%h", tag, field, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic rst, input logic [2:0] f, input logic [31:0] pc, input logic [31:0] mem);
    reset = rst;
    invalid_opcode = f[2];
    overflow = f[1];
    div_zero = f[0];
    pc_in = pc;
    mem_data_in = mem;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input out_t e);
    cmp(tag, "exc_busy",   32'(exc_busy),   32'(e.busy));
    cmp(tag, "mem_read",   32'(mem_read),   32'(e.mem_read));
    cmp(tag, "exc_addr",   exc_addr,        e.exc_addr);
    cmp(tag, "epc_write",  32'(epc_write),  32'(e.epc_write));
    cmp(tag, "epc_out",    epc_out,         e.epc_out);
    cmp(tag, "handler_pc", handler_pc,      e.handler_pc);
    cmp(tag, "ex_control", 32'(ex_control), 32'(e.redirect));
    cmp(tag, "pc_write",   32'(pc_write),   32'(e.redirect));
    cmp(tag, "exc_cause",  32'(exc_cause),  32'(e.cause));
  endtask

  // Reference model: cycles elapsed since the detection edge.
  int          m_phase = 0;
  logic [1:0]  m_vec = 2'd0;
  logic [1:0]  m_cause = 2'd0;
  logic [31:0] m_epc = 32'd0;
  logic [31:0] m_hp = 32'd0;
  logic        m_ew = 1'b0;

  task automatic model_step(input logic rst, input logic [2:0] f, input logic [31:0] pc, input logic [31:0] mem);
    if (rst) begin
      m_phase = 0; m_vec = 2'd0; m_cause = 2'd0; m_epc = 32'd0; m_hp = 32'd0; m_ew = 1'b0;
    end else begin
      m_ew = 1'b0;
      if (m_phase == 0) begin
        if (f != 3'b000) begin
          m_vec   = f[2] ? 2'd1 : (f[1] ? 2'd2 : 2'd3);
          m_cause = m_vec;
          m_epc   = pc - 32'd4;
          m_ew    = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == ML) begin
        m_hp    = mem & 32'h0000_00FF;
        m_phase = ML + 1;
      end else if (m_phase == ML + 1) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    logic [31:0] vec_addr [4];
    vec_addr[0] = 32'd0; vec_addr[1] = 32'd253; vec_addr[2] = 32'd254; vec_addr[3] = 32'd255;
    o.busy       = (m_phase != 0);
    o.mem_read   = (m_phase >= 1 && m_phase <= ML);
    o.exc_addr   = o.mem_read ? vec_addr[m_vec] : 32'd0;
    o.epc_write  = m_ew;
    o.epc_out    = m_epc;
    o.handler_pc = m_hp;
    o.redirect   = (m_phase == ML + 1);
    o.cause      = CAUSE_EN ? m_cause : 2'd0;
    return o;
  endfunction

  vec_t tbl [$];

  initial begin
    // flags = {invalid_opcode, overflow, div_zero}
    tbl.push_back(mk(1, 3'b000, 32'h0,   32'h0,        0,0,32'd0,  0,32'h0,        32'h0,  0,2'd0));
    tbl.push_back(mk(1, 3'b000, 32'h0,   32'h0,        0,0,32'd0,  0,32'h0,        32'h0,  0,2'd0));
    tbl.push_back(mk(0, 3'b000, 32'h40,  32'h0,        0,0,32'd0,  0,32'h0,        32'h0,  0,2'd0));
    tbl.push_back(mk(0, 3'b010, 32'h40,  32'hDEADBEEF, 1,1,32'd254,1,32'h3C,       32'h0,  0,2'd2));
    tbl.push_back(mk(0, 3'b000, 32'h44,  32'h12345600, 1,1,32'd254,0,32'h3C,       32'h0,  0,2'd2));
    tbl.push_back(mk(0, 3'b000, 32'h48,  32'h000000A7, 1,0,32'd0,  0,32'h3C,       32'hA7, 1,2'd2));
    tbl.push_back(mk(0, 3'b000, 32'h4C,  32'h55,       0,0,32'd0,  0,32'h3C,       32'hA7, 0,2'd2));
    tbl.push_back(mk(0, 3'b101, 32'h100, 32'h77,       1,1,32'd253,1,32'hFC,       32'hA7, 0,2'd1));
    tbl.push_back(mk(0, 3'b010, 32'h104, 32'h66,       1,1,32'd253,0,32'hFC,       32'hA7, 0,2'd1));
    tbl.push_back(mk(0, 3'b000, 32'h108, 32'h0000005B, 1,0,32'd0,  0,32'hFC,       32'h5B, 1,2'd1));
    tbl.push_back(mk(0, 3'b001, 32'h10C, 32'h44,       0,0,32'd0,  0,32'hFC,       32'h5B, 0,2'd1));
    tbl.push_back(mk(0, 3'b001, 32'h0,   32'h33,       1,1,32'd255,1,32'hFFFFFFFC, 32'h5B, 0,2'd3));
    tbl.push_back(mk(0, 3'b000, 32'h4,   32'h22,       1,1,32'd255,0,32'hFFFFFFFC, 32'h5B, 0,2'd3));
    tbl.push_back(mk(0, 3'b000, 32'h8,   32'hFFFFFF12, 1,0,32'd0,  0,32'hFFFFFFFC, 32'h12, 1,2'd3));
    tbl.push_back(mk(0, 3'b000, 32'h0,   32'h0,        0,0,32'd0,  0,32'hFFFFFFFC, 32'h12, 0,2'd3));
    tbl.push_back(mk(0, 3'b010, 32'h200, 32'h81,       1,1,32'd254,1,32'h1FC,      32'h12, 0,2'd2));
    tbl.push_back(mk(0, 3'b000, 32'h204, 32'h82,       1,1,32'd254,0,32'h1FC,      32'h12, 0,2'd2));
    tbl.push_back(mk(1, 3'b000, 32'h208, 32'h99,       0,0,32'd0,  0,32'h0,        32'h0,  0,2'd0));
    tbl.push_back(mk(0, 3'b000, 32'h20C, 32'h98,       0,0,32'd0,  0,32'h0,        32'h0,  0,2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].flags, tbl[i].pc, tbl[i].mem);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Long idle with no flags must never raise busy or a PC write.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'b000, 32'($urandom()), 32'($urandom()));
      cmp($sformatf("idle%0d", i), "exc_busy", 32'(exc_busy), 32'd0);
      cmp($sformatf("idle%0d", i), "pc_write", 32'(pc_write), 32'd0);
    end

    for (int i = 0; i < 2000; i++) begin
      logic        rst;
      logic [2:0]  f;
      logic [31:0] pc;
      logic [31:0] mem;
      rst = (i == 0) || ($urandom_range(0, 49) == 0);
      f   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pc  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom());
      mem = 32'($urandom());
      model_step(rst, f, pc, mem);
      applyStimulus(rst, f, pc, mem);
      checkOutput($sformatf("rand%0d", i), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_vector_unit.md
Name: exception_vector_unit

Overview:
- Multicycle-CPU exception sequencer; sits directly upstream of the exception/PC-source select mux.
- On an exception it:
  - captures EPC;
  - reads the handler byte from the fixed vector table in memory;
  - drives the mux select and the handler address into the mux's memory-path input;
  - pulses the PC write for one cycle.
- While active, it overrides normal PC sequencing.

Parameters:
- MEM_LATENCY, 2, cycles `mem_read` is held before `mem_data_in` is valid. Legal range: 1 to 15.
- VEC_BASE, 253, byte address of the first vector entry (opcode=253, overflow=254, div0=255).
- EPC_OFFSET, 4, value subtracted from `pc_in` to form EPC.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- invalid_opcode  in  1  exception flag from decode
- overflow  in  1  exception flag from ALU
- div_zero  in  1  exception flag from divider
- pc_in  in  32  current PC (already incremented)
- mem_data_in  in  32  memory read data; only bits [7:0] are used
- exc_addr  out  32  memory address during the vector read
- mem_read  out  1  memory read strobe
- epc_out  out  32  captured exception PC
- epc_write  out  1  one-cycle pulse when EPC is captured
- handler_pc  out  32  zero-extended handler address; feeds the mux memory-path input
- ex_control  out  1  mux select: 1 = handler_pc, 0 = normal PC source
- pc_write  out  1  one-cycle PC load request
- exc_busy  out  1  high whenever state is not IDLE
- exc_cause  out  2  0=none, 1=opcode, 2=overflow, 3=div0 (see optional feature)

Behaviour:
- Clock and reset:
  - Single clock domain: `clk`.
  - Reset is synchronous and active-high on `reset`.
  - Reset dominates every other input.
  - Reset forces state IDLE and sets every output and internal register to 0, including `epc_out`, `handler_pc` and the wait counter.
- States: IDLE, WAIT, REDIRECT.
- IDLE:
  - Flags are sampled at each rising edge.
  - If any flag is high:
    - cause is chosen by fixed priority: invalid_opcode > overflow > div_zero;
    - `epc_out` <= `pc_in` - EPC_OFFSET, modulo 2^32 (`pc_in` < 4 wraps, e.g. 0 -> 0xFFFFFFFC);
    - `epc_write` is high for exactly the cycle after that edge;
    - the counter is loaded with MEM_LATENCY-1;
    - next state is WAIT.
  - No flags: stay in IDLE.
  - All strobes are 0 in IDLE.
- WAIT:
  - `mem_read` = 1.
  - `exc_addr` = VEC_BASE + (cause-1), held stable for all MEM_LATENCY cycles.
  - The counter decrements each edge.
  - At the edge where the counter is 0:
    - `handler_pc` <= {24'b0, `mem_data_in[7:0]`};
    - next state is REDIRECT.
  - `exc_addr` = 0 outside WAIT.
- REDIRECT:
  - One cycle only.
  - `ex_control` = 1 and `pc_write` = 1.
  - Next state is IDLE.
  - Both outputs are registered state decodes and are 0 in every other state.
- Latency:
  - Detection edge -> `mem_read` high for cycles 1..MEM_LATENCY.
  - REDIRECT occurs in cycle MEM_LATENCY+1.
- Exception flags while `exc_busy`=1 are ignored; they are neither queued nor used to update the cause.
- A flag in the same cycle as REDIRECT is ignored. A flag in the first IDLE cycle after REDIRECT is accepted.
- `handler_pc` and `epc_out` hold their last values until the next exception or reset.
- Reset mid-operation (WAIT or REDIRECT):
  - state returns to IDLE the next cycle;
  - no `pc_write` pulse is produced.

Optional Feature:
- Macro: EXC_CAUSE_REG_EN.
- Defined:
  - `exc_cause` is a register loaded with the cause code at the detection edge;
  - it holds that code until the next exception or reset.
- Undefined:
  - `exc_cause` is tied to 2'b00;
  - no cause storage beyond the internal vector index.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: `reset`=1 for 2 cycles, no flags -> all outputs 0, `exc_busy`=0 indefinitely.
- Overflow, MEM_LATENCY=2: `pc_in`=0x00000040, `overflow`=1 for 1 cycle, memory returns 0x000000A7 at 254 ->
  - `epc_write` pulse with `epc_out`=0x0000003C;
  - `exc_addr`=254 with `mem_read`=1 for exactly 2 cycles;
  - next cycle `ex_control`=1, `pc_write`=1, `handler_pc`=0x000000A7;
  - then IDLE.
- Priority: `invalid_opcode`=1 and `div_zero`=1 together -> `exc_addr`=253; `exc_cause`=1 when EXC_CAUSE_REG_EN is defined, 0 when undefined.
- EPC wrap and upper-byte masking: `pc_in`=0x00000000, `div_zero`=1, `mem_data_in`=0xFFFFFF12 ->
  - `epc_out`=0xFFFFFFFC;
  - `exc_addr`=255;
  - `handler_pc`=0x00000012.
- Busy ignore and reset abort:
  - `overflow` pulsed during WAIT -> no change to the sequence; exactly one REDIRECT.
  - Separately, `reset` asserted in the 2nd WAIT cycle -> no `pc_write`, IDLE next cycle, all outputs 0.
